// File: rtl/pong_game_ctrl.sv
// Frame-synchronous pong sequencer: serve/play/over flow, BCD score, lives and ball speed.
// Optional attract-mode demo bounce in IDLE is enabled by defining PONG_ATTRACT_EN.
module pong_game_ctrl #(
  parameter int LIVES              = 3,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int SPEED_UP_HITS      = 8,
  parameter int MAX_STEP           = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       serve_btn,
  input  logic       paddle_hit,
  input  logic       miss,
  output logic       ball_load,
  output logic       ball_run,
  output logic [2:0] ball_step,
  output logic [7:0] score_bcd,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3
  } state_t;

  localparam logic [7:0] SERVE_LIMIT = (SERVE_DELAY_FRAMES == 0) ? 8'd1 : 8'(SERVE_DELAY_FRAMES);
  localparam logic [3:0] HIT_LIMIT   = 4'(SPEED_UP_HITS);
  localparam logic [2:0] STEP_MAX    = 3'(MAX_STEP);
  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);

  state_t     state_q;
  logic       ball_load_q, ball_run_q, game_over_q;
  logic [2:0] ball_step_q;
  logic [7:0] score_q;
  logic [1:0] lives_q;
  logic [7:0] frame_cnt_q;
  logic [3:0] hit_cnt_q;
  logic       btn_meta_q, btn_sync_q, btn_prev_q;
`ifdef PONG_ATTRACT_EN
  logic       boot_q;
`endif

  logic       start_d;
  logic [7:0] frame_cnt_d;
  logic [3:0] hit_cnt_d;
  logic [7:0] score_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    start_d     = btn_sync_q & ~btn_prev_q;
    frame_cnt_d = frame_cnt_q + 8'd1;
    hit_cnt_d   = hit_cnt_q + 4'd1;
    score_d     = bcd_inc(score_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ball_load_q <= 1'b0;
      ball_run_q  <= 1'b0;
      ball_step_q <= 3'd1;
      score_q     <= 8'h00;
      lives_q     <= LIVES_INIT;
      game_over_q <= 1'b0;
      frame_cnt_q <= 8'd0;
      hit_cnt_q   <= 4'd0;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      btn_prev_q  <= 1'b0;
`ifdef PONG_ATTRACT_EN
      boot_q      <= 1'b1;
`endif
    end else begin
      btn_meta_q  <= serve_btn;
      btn_sync_q  <= btn_meta_q;
      btn_prev_q  <= btn_sync_q;
      ball_load_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (state_q == ST_IDLE) begin
`ifdef PONG_ATTRACT_EN
            ball_run_q  <= 1'b1;
            ball_step_q <= 3'd1;
            if (boot_q) begin
              ball_load_q <= 1'b1;
              boot_q      <= 1'b0;
            end
`else
            ball_run_q <= 1'b0;
`endif
          end else begin
            ball_run_q  <= 1'b0;
            game_over_q <= 1'b1;
          end
          if (start_d) begin
            state_q     <= ST_SERVE;
            score_q     <= 8'h00;
            lives_q     <= LIVES_INIT;
            ball_step_q <= 3'd1;
            hit_cnt_q   <= 4'd0;
            frame_cnt_q <= 8'd0;
            ball_load_q <= 1'b1;
            ball_run_q  <= 1'b0;
            game_over_q <= 1'b0;
          end
        end

        ST_SERVE: begin
          ball_run_q <= 1'b0;
          if (frame_tick) begin
            if (frame_cnt_d == SERVE_LIMIT) begin
              state_q     <= ST_PLAY;
              frame_cnt_q <= 8'd0;
              ball_run_q  <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_d;
            end
          end
        end

        ST_PLAY: begin
          ball_run_q <= 1'b1;
          // A miss in the same cycle as a hit takes priority and drops the hit.
          if (miss) begin
            ball_run_q <= 1'b0;
            if (lives_q > 2'd1) begin
              lives_q     <= lives_q - 2'd1;
              state_q     <= ST_SERVE;
              ball_load_q <= 1'b1;
              frame_cnt_q <= 8'd0;
            end else begin
              lives_q     <= 2'd0;
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end
          end else if (paddle_hit) begin
            score_q <= score_d;
            if (hit_cnt_d == HIT_LIMIT) begin
              hit_cnt_q <= 4'd0;
              if (ball_step_q < STEP_MAX)
                ball_step_q <= ball_step_q + 3'd1;
            end else begin
              hit_cnt_q <= hit_cnt_d;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ball_load = ball_load_q;
  assign ball_run  = ball_run_q;
  assign ball_step = ball_step_q;
  assign score_bcd = score_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl; expected values are hand-computed constants.
module tb_pong_game_ctrl;

`ifdef PONG_ATTRACT_EN
  localparam bit ATTRACT = 1'b1;
`else
  localparam bit ATTRACT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       serve_btn = 1'b0;
  logic       paddle_hit = 1'b0;
  logic       miss = 1'b0;
  logic       ball_load, ball_run, game_over;
  logic [2:0] ball_step, state;
  logic [7:0] score_bcd;
  logic [1:0] lives;

  int n_cmp = 0;
  int n_fail = 0;

  pong_game_ctrl dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .serve_btn(serve_btn),
    .paddle_hit(paddle_hit), .miss(miss), .ball_load(ball_load), .ball_run(ball_run),
    .ball_step(ball_step), .score_bcd(score_bcd), .lives(lives), .game_over(game_over),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hit();
    paddle_hit = 1'b1; step(1); paddle_hit = 1'b0;
  endtask

  task automatic do_miss();
    miss = 1'b1; step(1); miss = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, {5'd0, state}, 8'd0);
    chk({tag, "_load"}, {7'd0, ball_load}, 8'd0);
    chk({tag, "_run"}, {7'd0, ball_run}, 8'd0);
    chk({tag, "_step"}, {5'd0, ball_step}, 8'd1);
    chk({tag, "_score"}, score_bcd, 8'h00);
    chk({tag, "_lives"}, {6'd0, lives}, 8'd3);
    chk({tag, "_over"}, {7'd0, game_over}, 8'd0);
  endtask

  task automatic start_game(input logic [2:0] prev_state);
    serve_btn = 1'b1;
    step(2);
    chk("start_latency", {5'd0, state}, {5'd0, prev_state});
    step(1);
    chk("start_state", {5'd0, state}, 8'd1);
    chk("start_load", {7'd0, ball_load}, 8'd1);
    chk("start_score", score_bcd, 8'h00);
    chk("start_lives", {6'd0, lives}, 8'd3);
    chk("start_step", {5'd0, ball_step}, 8'd1);
    chk("start_over", {7'd0, game_over}, 8'd0);
    chk("start_run", {7'd0, ball_run}, 8'd0);
    step(1);
    chk("start_load_end", {7'd0, ball_load}, 8'd0);
    serve_btn = 1'b0;
    step(3);
    chk("start_hold", {5'd0, state}, 8'd1);
  endtask

  task automatic serve_to_play();
    repeat (59) tick();
    chk("serve_59", {5'd0, state}, 8'd1);
    chk("serve_59_run", {7'd0, ball_run}, 8'd0);
    tick();
    chk("serve_60", {5'd0, state}, 8'd2);
    chk("serve_60_run", {7'd0, ball_run}, 8'd1);
  endtask

  initial begin
    #12;
    check_reset_vals("por");
    resetn = 1'b1;
    step(1);
    chk("rel_load", {7'd0, ball_load}, {7'd0, ATTRACT});
    step(1);
    chk("rel_load2", {7'd0, ball_load}, 8'd0);
    chk("rel_run", {7'd0, ball_run}, {7'd0, ATTRACT});
    step(3);
    chk("idle_state", {5'd0, state}, 8'd0);
    chk("idle_load", {7'd0, ball_load}, 8'd0);

    start_game(3'd0);
    serve_to_play();

    for (int i = 1; i <= 100; i++) begin
      hit();
      if (i == 8) begin
        chk("hit8_score", score_bcd, 8'h08);
        chk("hit8_step", {5'd0, ball_step}, 8'd2);
      end
      if (i == 7) chk("hit7_step", {5'd0, ball_step}, 8'd1);
      if (i == 9) chk("hit9_score", score_bcd, 8'h09);
      if (i == 10) chk("hit10_score", score_bcd, 8'h10);
      if (i == 16) chk("hit16_step", {5'd0, ball_step}, 8'd3);
      if (i == 24) chk("hit24_step", {5'd0, ball_step}, 8'd4);
      if (i == 32) begin
        chk("hit32_step", {5'd0, ball_step}, 8'd4);
        chk("hit32_score", score_bcd, 8'h32);
      end
      if (i == 99) chk("hit99_score", score_bcd, 8'h99);
      if (i == 100) chk("hit100_sat", score_bcd, 8'h99);
    end
    tick();
    chk("play_tick_ignored", {5'd0, state}, 8'd2);

    do_miss();
    chk("miss1_lives", {6'd0, lives}, 8'd2);
    chk("miss1_state", {5'd0, state}, 8'd1);
    chk("miss1_load", {7'd0, ball_load}, 8'd1);
    chk("miss1_run", {7'd0, ball_run}, 8'd0);
    step(1);
    chk("miss1_load_end", {7'd0, ball_load}, 8'd0);
    chk("miss1_score", score_bcd, 8'h99);
    chk("miss1_step", {5'd0, ball_step}, 8'd4);
    serve_to_play();
    do_miss();
    chk("miss2_lives", {6'd0, lives}, 8'd1);
    chk("miss2_state", {5'd0, state}, 8'd1);
    serve_to_play();
    do_miss();
    chk("miss3_lives", {6'd0, lives}, 8'd0);
    chk("miss3_state", {5'd0, state}, 8'd3);
    chk("miss3_over", {7'd0, game_over}, 8'd1);
    chk("miss3_run", {7'd0, ball_run}, 8'd0);
    chk("miss3_load", {7'd0, ball_load}, 8'd0);
    hit();
    chk("over_hit_ignored", score_bcd, 8'h99);

    start_game(3'd3);
    serve_to_play();
    repeat (5) hit();
    chk("hit5_score", score_bcd, 8'h05);
    do_miss();
    chk("m_lives2", {6'd0, lives}, 8'd2);
    serve_to_play();
    paddle_hit = 1'b1; miss = 1'b1;
    step(1);
    paddle_hit = 1'b0; miss = 1'b0;
    chk("both_score", score_bcd, 8'h05);
    chk("both_lives", {6'd0, lives}, 8'd1);
    chk("both_state", {5'd0, state}, 8'd1);
    step(1);
    hit();
    do_miss();
    step(1);
    chk("serve_ign_score", score_bcd, 8'h05);
    chk("serve_ign_lives", {6'd0, lives}, 8'd1);
    chk("serve_ign_state", {5'd0, state}, 8'd1);
    serve_to_play();
    hit();
    chk("pre_rst_score", score_bcd, 8'h06);

    #2;
    resetn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    #3;
    resetn = 1'b1;
    step(1);
    chk("rel2_load", {7'd0, ball_load}, {7'd0, ATTRACT});
    chk("rel2_state", {5'd0, state}, 8'd0);
    step(1);
    chk("rel2_load2", {7'd0, ball_load}, 8'd0);
    chk("rel2_run", {7'd0, ball_run}, {7'd0, ATTRACT});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
